// File: rtl/axilite_noc_req_sched.sv
// axilite_noc_req_sched: round-robin scheduler between the AXI-Lite read-address channel and the
// write-address/write-data pair. Each grant is serialized into a Piton NC load (3 flits) or NC
// store (4 flits) packet. Per-direction outstanding credits keep the response FIFO from overflowing.
// Optional build macro: AXILITE_NOC_SCHED_STATS_EN enables the 16-bit issued-request counters.

// Piton NoC field layout, used only when the project-wide define header has not been included.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_DST_CHIPID
`define MSG_DST_CHIPID 63:50
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define MSG_DST_FBITS 33:30
`define MSG_LENGTH 29:22
`define MSG_TYPE 21:14
`define MSG_MSHRID 13:6
`endif
`ifndef MSG_ADDR
`define MSG_ADDR_WIDTH 48
`define MSG_ADDR 63:16
`define MSG_DATA_SIZE 15:13
`endif
`ifndef MSG_SRC_CHIPID
`define MSG_SRC_CHIPID 63:50
`define MSG_SRC_X 49:42
`define MSG_SRC_Y 41:34
`endif
`ifndef MSG_TYPE_NC_LOAD_REQ
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif
`ifndef MSG_DATA_SIZE_8B
`define MSG_DATA_SIZE_8B 3'b100
`endif

module axilite_noc_req_sched #(
  parameter int unsigned AXI_LITE_ADDR_WIDTH = 64,
  parameter int unsigned AXI_LITE_DATA_WIDTH = 64,
  parameter int unsigned MAX_OUTSTANDING     = 16,
  parameter logic [13:0] DST_CHIPID          = 14'd0,
  parameter logic [7:0]  DST_X               = 8'd0,
  parameter logic [7:0]  DST_Y               = 8'd0,
  parameter logic [3:0]  DST_FBITS           = 4'b0,
  parameter logic [13:0] SRC_CHIPID          = 14'd0,
  parameter logic [7:0]  SRC_X               = 8'd0,
  parameter logic [7:0]  SRC_Y               = 8'd0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  input  logic                             rd_resp_done,
  input  logic                             wr_resp_done,
  output logic                             noc_valid_out,
  output logic [`NOC_DATA_WIDTH-1:0]       noc_data_out,
  input  logic                             noc_ready_in,
  output logic                             err_partial_wr,
  output logic [15:0]                      rd_issue_count,
  output logic [15:0]                      wr_issue_count
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);
  localparam int unsigned AddrW = `MSG_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StHdr2, StData} state_e;

  state_e                          state_q;
  logic                            rr_wr_q;     // 0: read wins a tie, 1: write wins a tie
  logic [7:0]                      tag_q;
  logic [CntW-1:0]                 rd_out_q, rd_out_d;
  logic [CntW-1:0]                 wr_out_q, wr_out_d;
  logic [AddrW-1:0]                addr_q;
  logic [AXI_LITE_DATA_WIDTH-1:0]  wdata_q;
  logic                            is_store_q;
  logic                            err_q;
  logic                            noc_valid_q;
  logic [`NOC_DATA_WIDTH-1:0]      noc_data_q;

  logic rd_elig, wr_elig, grant_rd, grant_wr, rd_hs, wr_hs, flit_adv, rd_dec, wr_dec;
  logic [`NOC_DATA_WIDTH-1:0] hdr0, hdr1, hdr2;

  // Address bits above the NoC address width are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

  // Eligibility, round-robin grant and combinational readies (only in IDLE, only out of reset).
  always_comb begin
    rd_elig  = s_axi_arvalid && (rd_out_q < MaxCnt);
    wr_elig  = s_axi_awvalid && s_axi_wvalid && (wr_out_q < MaxCnt);
    grant_rd = rd_elig && (!wr_elig || !rr_wr_q);
    grant_wr = wr_elig && (!rd_elig || rr_wr_q);
    s_axi_arready = rst_n && (state_q == StIdle) && grant_rd;
    s_axi_awready = rst_n && (state_q == StIdle) && grant_wr;
    s_axi_wready  = s_axi_awready;
    rd_hs    = s_axi_arready;
    wr_hs    = s_axi_awready;
    flit_adv = noc_valid_q && noc_ready_in;
  end

  // Outstanding credit counters; a done pulse with nothing outstanding is dropped.
  always_comb begin
    rd_dec   = rd_resp_done && (rd_out_q != '0);
    wr_dec   = wr_resp_done && (wr_out_q != '0);
    rd_out_d = rd_out_q;
    wr_out_d = wr_out_q;
    if (rd_hs && !rd_dec) rd_out_d = rd_out_q + CntW'(1);
    if (!rd_hs && rd_dec) rd_out_d = rd_out_q - CntW'(1);
    if (wr_hs && !wr_dec) wr_out_d = wr_out_q + CntW'(1);
    if (!wr_hs && wr_dec) wr_out_d = wr_out_q - CntW'(1);
  end

  // Header flit images; hdr0 is built from the request being handshaken this cycle.
  always_comb begin
    hdr0 = '0;
    hdr0[`MSG_DST_CHIPID] = DST_CHIPID;
    hdr0[`MSG_DST_X]      = DST_X;
    hdr0[`MSG_DST_Y]      = DST_Y;
    hdr0[`MSG_DST_FBITS]  = DST_FBITS;
    hdr0[`MSG_LENGTH]     = wr_hs ? 8'd3 : 8'd2;
    hdr0[`MSG_TYPE]       = wr_hs ? `MSG_TYPE_NC_STORE_REQ : `MSG_TYPE_NC_LOAD_REQ;
    hdr0[`MSG_MSHRID]     = tag_q;
    hdr1 = '0;
    hdr1[`MSG_ADDR]       = addr_q;
    hdr1[`MSG_DATA_SIZE]  = `MSG_DATA_SIZE_8B;
    hdr2 = '0;
    hdr2[`MSG_SRC_CHIPID] = SRC_CHIPID;
    hdr2[`MSG_SRC_X]      = SRC_X;
    hdr2[`MSG_SRC_Y]      = SRC_Y;
  end

  // Packet FSM with registered flit outputs, request capture, tag, credits and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_wr_q     <= 1'b0;
      tag_q       <= '0;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      err_q       <= 1'b0;
      noc_valid_q <= 1'b0;
      noc_data_q  <= '0;
    end else begin
      rd_out_q <= rd_out_d;
      wr_out_q <= wr_out_d;
      unique case (state_q)
        StIdle: begin
          if (rd_hs || wr_hs) begin
            state_q     <= StHdr0;
            noc_valid_q <= 1'b1;
            noc_data_q  <= hdr0;
            addr_q      <= wr_hs ? s_axi_awaddr[AddrW-1:0] : s_axi_araddr[AddrW-1:0];
            is_store_q  <= wr_hs;
            tag_q       <= tag_q + 8'd1;
            rr_wr_q     <= rd_hs;
            if (wr_hs) wdata_q <= s_axi_wdata;
            if (wr_hs && (s_axi_wstrb != '1)) err_q <= 1'b1;
          end
        end
        StHdr0: begin
          if (flit_adv) begin
            state_q    <= StHdr1;
            noc_data_q <= hdr1;
          end
        end
        StHdr1: begin
          if (flit_adv) begin
            state_q    <= StHdr2;
            noc_data_q <= hdr2;
          end
        end
        StHdr2: begin
          if (flit_adv) begin
            if (is_store_q) begin
              state_q    <= StData;
              noc_data_q <= wdata_q;
            end else begin
              state_q     <= StIdle;
              noc_valid_q <= 1'b0;
            end
          end
        end
        StData: begin
          if (flit_adv) begin
            state_q     <= StIdle;
            noc_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign noc_valid_out  = noc_valid_q;
  assign noc_data_out   = noc_data_q;
  assign err_partial_wr = err_q;

`ifdef AXILITE_NOC_SCHED_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // Free-running issued-request counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_hs) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_hs) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_issue_count = rd_cnt_q;
  assign wr_issue_count = wr_cnt_q;
`else
  assign rd_issue_count = 16'd0;
  assign wr_issue_count = 16'd0;
`endif

endmodule

// File: tb/tb_axilite_noc_req_sched.sv
// Scoreboard bench for axilite_noc_req_sched: a queue-based reference model predicts readies,
// grants and the flit stream; a separate monitor compares every presented flit against it.
module tb_axilite_noc_req_sched;

  localparam int MaxOut = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] araddr, awaddr, wdata;
  logic [7:0]  wstrb;
  logic        arvalid, awvalid, wvalid;
  logic        arready, awready, wready;
  logic        rd_done, wr_done;
  logic        noc_valid;
  logic [63:0] noc_data;
  logic        noc_ready;
  logic        err_pw;
  logic [15:0] rd_cnt, wr_cnt;

  always #5 clk = ~clk;

  axilite_noc_req_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axi_araddr   (araddr),
    .s_axi_arvalid  (arvalid),
    .s_axi_arready  (arready),
    .s_axi_awaddr   (awaddr),
    .s_axi_awvalid  (awvalid),
    .s_axi_awready  (awready),
    .s_axi_wdata    (wdata),
    .s_axi_wstrb    (wstrb),
    .s_axi_wvalid   (wvalid),
    .s_axi_wready   (wready),
    .rd_resp_done   (rd_done),
    .wr_resp_done   (wr_done),
    .noc_valid_out  (noc_valid),
    .noc_data_out   (noc_data),
    .noc_ready_in   (noc_ready),
    .err_partial_wr (err_pw),
    .rd_issue_count (rd_cnt),
    .wr_issue_count (wr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] exp_q[$];
  bit          fresh;        // flits pushed this cycle appear from the next cycle on
  int          rd_out_m, wr_out_m, tag_m, rd_cnt_m, wr_cnt_m;
  bit          rr_wr_m, err_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Piton header layouts for the default DST/SRC parameters (all zero).
  function automatic logic [63:0] mk_hdr0(input bit st, input logic [7:0] tag);
    logic [63:0] f;
    f = '0;
    f[29:22] = st ? 8'd3 : 8'd2;
    f[21:14] = st ? 8'd15 : 8'd14;
    f[13:6]  = tag;
    return f;
  endfunction

  function automatic logic [63:0] mk_hdr1(input logic [63:0] a);
    logic [63:0] f;
    f = '0;
    f[63:16] = a[47:0];
    f[15:13] = 3'b100;
    return f;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fresh    = 1'b0;
    rd_out_m = 0;
    wr_out_m = 0;
    tag_m    = 0;
    rd_cnt_m = 0;
    wr_cnt_m = 0;
    rr_wr_m  = 1'b0;
    err_m    = 1'b0;
  endtask

  // Model: predict readies from credits, round-robin and busy state; enqueue expected flits.
  always @(negedge clk) begin
    bit idle, rde, wre, ear, eaw;
    if (!rst_n) begin
      chk("arready_in_reset", arready, 0);
      chk("awready_in_reset", awready, 0);
      chk("wready_in_reset", wready, 0);
      model_reset();
    end else begin
      idle = (exp_q.size() == 0);
      rde  = arvalid && (rd_out_m < MaxOut);
      wre  = awvalid && wvalid && (wr_out_m < MaxOut);
      ear  = idle && rde && (!wre || !rr_wr_m);
      eaw  = idle && wre && (!rde || rr_wr_m);
      chk("arready", arready, ear);
      chk("awready", awready, eaw);
      chk("wready", wready, eaw);
      chk("err_partial_wr", err_pw, err_m);
`ifdef AXILITE_NOC_SCHED_STATS_EN
      chk("rd_issue_count", rd_cnt, rd_cnt_m[15:0]);
      chk("wr_issue_count", wr_cnt, wr_cnt_m[15:0]);
`else
      chk("rd_issue_count", rd_cnt, 0);
      chk("wr_issue_count", wr_cnt, 0);
`endif
      if (ear) begin
        exp_q.push_back(mk_hdr0(1'b0, tag_m[7:0]));
        exp_q.push_back(mk_hdr1(araddr));
        exp_q.push_back(64'd0);
        fresh    = 1'b1;
        tag_m    = (tag_m + 1) % 256;
        rd_out_m++;
        rd_cnt_m = (rd_cnt_m + 1) % 65536;
        rr_wr_m  = 1'b1;
      end else if (eaw) begin
        exp_q.push_back(mk_hdr0(1'b1, tag_m[7:0]));
        exp_q.push_back(mk_hdr1(awaddr));
        exp_q.push_back(64'd0);
        exp_q.push_back(wdata);
        fresh    = 1'b1;
        tag_m    = (tag_m + 1) % 256;
        wr_out_m++;
        wr_cnt_m = (wr_cnt_m + 1) % 65536;
        rr_wr_m  = 1'b0;
        if (wstrb != 8'hFF) err_m = 1'b1;
      end
      if (rd_done && rd_out_m > 0) rd_out_m--;
      if (wr_done && wr_out_m > 0) wr_out_m--;
    end
  end

  // Monitor: compare the presented flit with the scoreboard head; pop on acceptance.
  always @(negedge clk) begin
    bit ev;
    #2;
    if (rst_n) begin
      ev = (exp_q.size() != 0) && !fresh;
      chk("noc_valid_out", noc_valid, ev);
      if (ev && noc_valid) begin
        chk("noc_data_out", noc_data, exp_q[0]);
        if (noc_ready) void'(exp_q.pop_front());
      end
    end
    fresh = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    arvalid = 0; awvalid = 0; wvalid = 0; rd_done = 0; wr_done = 0;
  endtask

  // Retire every outstanding request and let the scheduler go idle, with a cycle budget.
  task automatic drain();
    int n;
    quiet();
    noc_ready = 1;
    n = 0;
    while ((exp_q.size() != 0 || rd_out_m > 0 || wr_out_m > 0) && n < 300) begin
      rd_done = (rd_out_m > 0);
      wr_done = (wr_out_m > 0);
      step();
      n++;
    end
    rd_done = 0;
    wr_done = 0;
    step();
    chk("drain_within_budget", (n < 300), 1);
  endtask

  initial begin
    rst_n = 0; noc_ready = 0; araddr = '0; awaddr = '0; wdata = '0; wstrb = 8'hFF;
    quiet();
    repeat (3) step();
    chk("reset_noc_valid", noc_valid, 0);
    chk("reset_noc_data", noc_data, 0);
    chk("reset_err", err_pw, 0);
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_wr_cnt", wr_cnt, 0);
    rst_n = 1;
    step();

    // Single read and single write.
    noc_ready = 1;
    araddr = 64'h0000_1000_0040; arvalid = 1;
    step();
    arvalid = 0;
    repeat (5) step();
    awaddr = 64'h0000_0000_2000_0080; wdata = 64'hDEAD_BEEF_0123_4567; wstrb = 8'hFF;
    awvalid = 1; wvalid = 1;
    step();
    quiet();
    repeat (6) step();
    drain();

    // Contention: grants alternate with read first after the previous write grant.
    arvalid = 1; awvalid = 1; wvalid = 1;
    repeat (36) step();
    drain();

    // Credit exhaustion on both directions, then a single read credit returned.
    arvalid = 1; awvalid = 1; wvalid = 1;
    repeat (160) step();
    rd_done = 1;
    step();
    rd_done = 0;
    repeat (12) step();
    drain();

    // Back-pressure during HDR1.
    araddr = 64'h0000_00AB_CDEF_0008; arvalid = 1;
    step();
    arvalid = 0;
    step();
    noc_ready = 0;
    repeat (5) step();
    noc_ready = 1;
    repeat (4) step();
    drain();

    // Partial-strobe store sets the sticky error.
    awaddr = 64'h40; wdata = 64'h1111_2222_3333_4444; wstrb = 8'h0F; awvalid = 1; wvalid = 1;
    step();
    quiet();
    wstrb = 8'hFF;
    repeat (8) step();
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      arvalid   = $urandom_range(0, 1);
      awvalid   = $urandom_range(0, 1);
      wvalid    = $urandom_range(0, 1);
      araddr    = {$urandom, $urandom};
      awaddr    = {$urandom, $urandom};
      wdata     = {$urandom, $urandom};
      wstrb     = ($urandom_range(0, 7) == 0) ? 8'h0F : 8'hFF;
      noc_ready = ($urandom_range(0, 3) != 0);
      rd_done   = (rd_out_m > 0) && ($urandom_range(0, 2) == 0);
      wr_done   = (wr_out_m > 0) && ($urandom_range(0, 2) == 0);
      step();
    end
    drain();

    // Reset in the middle of a store.
    awaddr = 64'h80; wdata = 64'hCAFE_F00D_0000_0001; wstrb = 8'h0F; awvalid = 1; wvalid = 1;
    step();
    quiet();
    step();
    rst_n = 0;
    step();
    chk("mid_reset_noc_valid", noc_valid, 0);
    chk("mid_reset_err", err_pw, 0);
    chk("mid_reset_rd_cnt", rd_cnt, 0);
    chk("mid_reset_wr_cnt", wr_cnt, 0);
    rst_n = 1;
    repeat (3) step();

    // Fresh read after reset: MSHRID restarts at 0.
    araddr = 64'h0000_0000_0000_0100; arvalid = 1;
    step();
    arvalid = 0;
    drain();
    repeat (4) step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
